// File: rtl/jesd_sync_pkg.sv
// jesd_sync_pkg: shared state encodings and counter widths for the JESD204B SYNC~ request controller.
package jesd_sync_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REQ       = 3'd1;
    localparam logic [2:0] ST_ILAS_WAIT = 3'd2;
    localparam logic [2:0] ST_LINKED    = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    localparam int HOLD_W  = 8;
    localparam int TO_W    = 8;
    localparam int RETRY_W = 4;

    function automatic int lmfc_width(input int period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/jesd_lmfc_cnt.sv
// jesd_lmfc_cnt: free-running LMFC counter with boundary flag.
// Optional SYSREF edge realignment when SYSREF_ALIGN_EN is defined.
module jesd_lmfc_cnt
    import jesd_sync_pkg::*;
#(
    parameter int LMFC_PERIOD = 16,
    parameter int CW          = lmfc_width(LMFC_PERIOD)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sysref_i,
    output logic [CW-1:0] cnt_o,
    output logic          boundary_o
);

    logic [CW-1:0] cnt_q, cnt_d, cnt_wrap;

    assign cnt_wrap = (cnt_q == CW'(LMFC_PERIOD - 1)) ? '0 : cnt_q + 1'b1;

`ifdef SYSREF_ALIGN_EN
    logic sysref_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sysref_q <= 1'b0;
        else       sysref_q <= sysref_i;
    end

    // a rise on the natural wrap also lands on zero, so it is harmless
    assign cnt_d = (sysref_i && !sysref_q) ? '0 : cnt_wrap;
`else
    logic unused_sysref;

    assign unused_sysref = sysref_i;
    assign cnt_d         = cnt_wrap;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o      = cnt_q;
    assign boundary_o = (cnt_q == '0);

endmodule

// File: rtl/jesd_sync_req_ctrl.sv
// jesd_sync_req_ctrl: drives SYNC~ aligned to LMFC, supervises ILAS with timeout, retry and link-lost restart.
// Optional SYSREF realignment of the LMFC counter via macro SYSREF_ALIGN_EN.
module jesd_sync_req_ctrl
    import jesd_sync_pkg::*;
#(
    parameter int LMFC_PERIOD = 16,
    parameter int MIN_HOLD_MF = 4,
    parameter int ILAS_TO_MF  = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         SYNC_TRIG,
    input  logic         SYSREF,
    input  logic         CGS_OK,
    input  logic         ILAS_START,
    input  logic         LINK_ERR,
    output logic         SYNCN,
    output logic         LMFC_TICK,
    output logic [2:0]   STATE,
    output logic         LINKED,
    output logic         FAIL,
    output logic [3:0]   RETRY_CNT
);

    localparam int CW = lmfc_width(LMFC_PERIOD);

    logic [CW-1:0]      unused_lmfc_cnt;
    logic               boundary;
    logic [2:0]         state_q, state_d;
    logic               syncn_q, syncn_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    jesd_lmfc_cnt #(
        .LMFC_PERIOD (LMFC_PERIOD),
        .CW          (CW)
    ) u_lmfc (
        .clk_i      (CLK),
        .rst_i      (RST),
        .sysref_i   (SYSREF),
        .cnt_o      (unused_lmfc_cnt),
        .boundary_o (boundary)
    );

    // hold_q is compared before its own increment in the release cycle
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        to_d    = to_q;
        retry_d = retry_q;
        if (SYNC_TRIG) begin
            state_d = ST_REQ;
            hold_d  = '0;
            to_d    = '0;
            retry_d = '0;
        end else if (state_q == ST_REQ) begin
            if (boundary) begin
                hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
                if (hold_q >= HOLD_W'(MIN_HOLD_MF) && CGS_OK) begin
                    state_d = ST_ILAS_WAIT;
                    to_d    = '0;
                end
            end
        end else if (state_q == ST_ILAS_WAIT) begin
            if (ILAS_START) begin
                state_d = ST_LINKED;
            end else if (boundary) begin
                to_d = to_q + 1'b1;
                if (to_q == TO_W'(ILAS_TO_MF - 1)) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_REQ;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
        end else if (state_q == ST_LINKED && LINK_ERR) begin
            state_d = ST_REQ;
            retry_d = '0;
            hold_d  = '0;
        end
        syncn_d = (state_d != ST_REQ);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            syncn_q <= 1'b1;
            hold_q  <= '0;
            to_q    <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            syncn_q <= syncn_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            retry_q <= retry_d;
        end
    end

    assign SYNCN     = syncn_q;
    assign LMFC_TICK = boundary;
    assign STATE     = state_q;
    assign LINKED    = (state_q == ST_LINKED);
    assign FAIL      = (state_q == ST_FAIL);
    assign RETRY_CNT = retry_q;

endmodule

// File: doc/jesd_sync_req_ctrl.md
Name: jesd_sync_req_ctrl

Overview:
Downstream consumer of the one-pulse SYNC trigger produced by the 160 MHz sync generator. It drives the JESD204B receiver SYNC~ request (SYNCN, active-low) and aligns its release to an internal LMFC counter. It then supervises the ILAS start, with timeout, bounded retry and a link-lost restart. It sits between the trigger generator and the SYNC~ pin / lane status logic of the RX core.

Parameters:
LMFC_PERIOD, 16, CLK cycles per multiframe (K=32, F=2, 4 octets/clk); legal range 2..256
MIN_HOLD_MF, 4, minimum LMFC boundaries SYNCN stays low before release is allowed; 1..255
ILAS_TO_MF, 8, LMFC boundaries allowed in ILAS_WAIT before timeout; 1..255
MAX_RETRY, 3, timeouts tolerated before FAIL; 0..15

Ports:
CLK  in  1  fabric clock, 160 MHz
RST  in  1  synchronous, active-high reset
SYNC_TRIG  in  1  one-cycle start pulse from the sync generator
SYSREF  in  1  SYSREF sampled in CLK domain (used only with SYSREF_ALIGN_EN)
CGS_OK  in  1  all lanes have code-group sync (level)
ILAS_START  in  1  one-cycle pulse: ILAS /R/ detected on all lanes
LINK_ERR  in  1  one-cycle pulse: lane error or loss of sync while linked
SYNCN  out  1  SYNC~ request, active-low, registered
LMFC_TICK  out  1  high in every cycle where lmfc_cnt==0
STATE  out  3  current FSM state encoding
LINKED  out  1  high in LINKED
FAIL  out  1  high in FAIL
RETRY_CNT  out  4  timeouts since last SYNC_TRIG or LINK_ERR

Behaviour:
- Reset values (RST=1 at a CLK edge): state=IDLE, SYNCN=1, lmfc_cnt=0, hold_cnt=0, to_cnt=0, RETRY_CNT=0, LINKED=0, FAIL=0. Reset mid-operation aborts immediately, with the same values the next cycle.
- LMFC: lmfc_cnt runs 0..LMFC_PERIOD-1 and wraps to 0. The boundary is the cycle with lmfc_cnt==0. LMFC_TICK is decoded from the register, with no extra latency.
- State encoding: IDLE=0, REQ=1, ILAS_WAIT=2, LINKED=3, FAIL=4. All outputs are registered or decoded from state. Each transition takes effect the cycle after the qualifying edge.
- Priority (highest first): RST > SYNC_TRIG > ILAS_START / LINK_ERR > timeout / release.
- SYNC_TRIG in any state, including REQ, moves to REQ, sets SYNCN=0, clears hold_cnt, to_cnt and RETRY_CNT, and clears FAIL.
- IDLE: SYNCN=1. Waits for SYNC_TRIG.
- REQ:
  - SYNCN=0.
  - hold_cnt increments on each boundary and saturates at 255.
  - Release condition: boundary cycle AND hold_cnt>=MIN_HOLD_MF (value before that cycle's increment) AND CGS_OK=1.
  - On release: go to ILAS_WAIT, SYNCN=1, to_cnt=0. Without CGS_OK, REQ holds indefinitely.
- ILAS_WAIT:
  - SYNCN=1. to_cnt increments on each boundary.
  - ILAS_START: go to LINKED. It wins over a same-cycle timeout.
  - Timeout: boundary with to_cnt==ILAS_TO_MF-1.
    - If RETRY_CNT<MAX_RETRY: RETRY_CNT+1, go to REQ, clear hold_cnt.
    - Otherwise: go to FAIL.
- LINKED: SYNCN=1, LINKED=1. LINK_ERR goes to REQ with RETRY_CNT=0 and hold_cnt=0. ILAS_START is ignored.
- FAIL: SYNCN=1, FAIL=1. Only SYNC_TRIG or RST exits. ILAS_START, LINK_ERR and CGS_OK are ignored.
- ILAS_START and LINK_ERR are ignored in IDLE and REQ.
- RETRY_CNT never exceeds MAX_RETRY.

Optional Feature:
SYSREF_ALIGN_EN
- Defined: SYSREF is registered once (sysref_q). A rising edge (SYSREF=1, sysref_q=0) forces lmfc_cnt=0 on the next cycle; that cycle counts as a boundary. An edge landing exactly on the natural wrap is harmless.
- Undefined: lmfc_cnt free-runs from reset, the SYSREF port is ignored, and no edge logic is synthesized.

Decomposition:
- Package jesd_sync_pkg holds:
  - state encoding constants (IDLE..FAIL);
  - counter widths: 8-bit hold/timeout counters, 4-bit retry counter, LMFC counter width derived from LMFC_PERIOD.
- One sub-module, jesd_lmfc_cnt: holds the LMFC counter and the SYSREF edge realignment. It outputs lmfc_cnt and the boundary flag.
- The FSM stays in jesd_sync_req_ctrl.

Test Plan:
(All scenarios use defaults: LMFC_PERIOD=16, MIN_HOLD_MF=4, ILAS_TO_MF=8, MAX_RETRY=3.)
- Reset and free run: RST high 3 cycles, then low. SYNCN=1, STATE=0, and LMFC_TICK pulses every 16 cycles starting at the first post-reset cycle.
- Nominal link: CGS_OK=1 tied, SYNC_TRIG pulse. SYNCN falls 1 cycle later and rises exactly at the 5th boundary after entry. ILAS_START 20 cycles later gives LINKED=1, STATE=3.
- Late CGS: CGS_OK held 0 for 10 multiframes, then 1. SYNCN stays 0 and releases at the first boundary after CGS_OK rises.
- Timeout/retry/fail: never assert ILAS_START. RETRY_CNT steps 1,2,3 with SYNCN re-asserting each time. The 4th timeout gives FAIL=1, SYNCN=1, STATE=4. A new SYNC_TRIG gives REQ and RETRY_CNT=0.
- Link loss and collisions:
  - LINK_ERR in LINKED gives REQ with SYNCN=0.
  - SYNC_TRIG and ILAS_START in the same cycle of ILAS_WAIT gives REQ.
  - RST during REQ gives SYNCN=1 next cycle.
- SYSREF_ALIGN_EN: with the macro defined, a SYSREF rise at lmfc_cnt=7 gives lmfc_cnt=0 and LMFC_TICK=1 next cycle. The same stimulus without the macro leaves the tick phase unchanged.
